// File: rtl/rd84_operand_sequencer.sv
// Serial operand loader, fixed-window evaluation hold and result handshake around the rd84 evaluator.
// Optional macro RD84_POPCNT_EN adds res_popcnt, the count of 1-bits in the returned operand.
module rd84_operand_sequencer #(
  parameter int WIDTH       = 8,
  parameter int EVAL_CYCLES = 4,
  parameter int CNT_W       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] x_out,
  output logic             x_valid,
  output logic             eval_start,
  input  logic             z_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_data
`ifdef RD84_POPCNT_EN
  ,
  output logic [CNT_W-1:0] res_popcnt
`endif
);

  localparam int ECNT_W = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;

  generate
    if (EVAL_CYCLES < 1) begin : g_bad_eval_cycles
      $error("rd84_operand_sequencer: EVAL_CYCLES must be at least 1");
    end
    if (WIDTH < 2) begin : g_bad_width
      $error("rd84_operand_sequencer: WIDTH must be at least 2");
    end
  endgenerate

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready, x_valid, res_valid and eval_start are registers, so no input reaches an output combinationally.
  typedef enum logic [1:0] {
    LOAD = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ECNT_W-1:0] ecnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOAD;
      cnt        <= '0;
      ecnt       <= '0;
      x_out      <= '0;
      res_data   <= 1'b0;
      in_ready   <= 1'b1;
      x_valid    <= 1'b0;
      eval_start <= 1'b0;
      res_valid  <= 1'b0;
`ifdef RD84_POPCNT_EN
      res_popcnt <= '0;
`endif
    end else if (clear) begin
      // x_out deliberately keeps its contents; only the control state is unwound
      state      <= LOAD;
      cnt        <= '0;
      ecnt       <= '0;
      in_ready   <= 1'b1;
      x_valid    <= 1'b0;
      eval_start <= 1'b0;
      res_valid  <= 1'b0;
`ifdef RD84_POPCNT_EN
      res_popcnt <= '0;
`endif
    end else begin
      case (state)
        LOAD: begin
          if (in_valid && in_ready) begin
            for (int k = 0; k < WIDTH; k++) begin
              if (cnt == CNT_W'(k)) x_out[k] <= in_bit;
            end
`ifdef RD84_POPCNT_EN
            res_popcnt <= res_popcnt + {{(CNT_W-1){1'b0}}, in_bit};
`endif
            if (cnt == CNT_W'(WIDTH - 1)) begin
              cnt        <= '0;
              ecnt       <= '0;
              state      <= EVAL;
              in_ready   <= 1'b0;
              x_valid    <= 1'b1;
              eval_start <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        EVAL: begin
          eval_start <= 1'b0;
          // z_in is only trusted at the end of the last cycle of the hold window
          if (ecnt == ECNT_W'(EVAL_CYCLES - 1)) begin
            res_data  <= z_in;
            res_valid <= 1'b1;
            state     <= RESP;
          end else begin
            ecnt <= ecnt + ECNT_W'(1);
          end
        end
        RESP: begin
          if (res_ready) begin
            state     <= LOAD;
            res_valid <= 1'b0;
            x_valid   <= 1'b0;
            in_ready  <= 1'b1;
`ifdef RD84_POPCNT_EN
            res_popcnt <= '0;
`endif
          end
        end
        default: begin
          state      <= LOAD;
          cnt        <= '0;
          ecnt       <= '0;
          in_ready   <= 1'b1;
          x_valid    <= 1'b0;
          eval_start <= 1'b0;
          res_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rd84_operand_sequencer.sv
// Self-checking bench for rd84_operand_sequencer: scoreboard of expected results, latency and handshake checks.
module tb_rd84_operand_sequencer;

  localparam int WIDTH       = 8;
  localparam int EVAL_CYCLES = 4;
  localparam int CNT_W       = $clog2(WIDTH + 1);
  localparam int EW          = 1 + CNT_W + WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clear = 1'b0;
  logic             in_bit = 1'b0;
  logic             in_valid = 1'b0;
  logic             z_in = 1'b0;
  logic             res_ready = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] x_out;
  logic             x_valid;
  logic             eval_start;
  logic             res_valid;
  logic             res_data;
`ifdef RD84_POPCNT_EN
  logic [CNT_W-1:0] res_popcnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_e;

  rd84_operand_sequencer #(
    .WIDTH(WIDTH),
    .EVAL_CYCLES(EVAL_CYCLES),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .in_bit(in_bit),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .x_out(x_out),
    .x_valid(x_valid),
    .eval_start(eval_start),
    .z_in(z_in),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data)
`ifdef RD84_POPCNT_EN
    ,
    .res_popcnt(res_popcnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: compare on the edge where the result handshake completes
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_e = exp_q.pop_front();
        check("res_data", {31'd0, res_data}, {31'd0, exp_e[EW-1]});
        check("res_x_out", {24'd0, x_out}, {24'd0, exp_e[WIDTH-1:0]});
`ifdef RD84_POPCNT_EN
        check("res_popcnt", {28'd0, res_popcnt}, {28'd0, exp_e[WIDTH +: CNT_W]});
`endif
      end
    end
  end

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_x_valid"}, {31'd0, x_valid}, 32'd0);
    check({tag, "_eval_start"}, {31'd0, eval_start}, 32'd0);
    check({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
    check({tag, "_res_data"}, {31'd0, res_data}, 32'd0);
    check({tag, "_x_out"}, {24'd0, x_out}, 32'd0);
`ifdef RD84_POPCNT_EN
    check({tag, "_popcnt"}, {28'd0, res_popcnt}, 32'd0);
`endif
  endtask

  task automatic load_bits(input logic [WIDTH-1:0] op, input bit gap);
    int waited;
    for (int k = 0; k < WIDTH; k++) begin
      waited = 0;
      in_bit = op[k];
      in_valid = 1'b1;
      while (!in_ready && waited < 20) begin
        tick();
        waited++;
      end
      if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
      tick();
      in_valid = 1'b0;
      if (gap && k != WIDTH - 1) tick();
    end
  endtask

  // entered one ns into the first EVAL cycle (T+1)
  task automatic eval_phase(input logic [WIDTH-1:0] op, input logic [EVAL_CYCLES-1:0] zpat);
    check("eval_start_first", {31'd0, eval_start}, 32'd1);
    check("x_valid_eval", {31'd0, x_valid}, 32'd1);
    check("in_ready_eval", {31'd0, in_ready}, 32'd0);
    check("x_out_eval", {24'd0, x_out}, {24'd0, op});
    for (int e = 0; e < EVAL_CYCLES; e++) begin
      z_in = zpat[e];
      if (e > 0) check("eval_start_later", {31'd0, eval_start}, 32'd0);
      check("res_valid_early", {31'd0, res_valid}, 32'd0);
      tick();
    end
    z_in = 1'b0;
    check("res_valid_latency", {31'd0, res_valid}, 32'd1);
    check("x_valid_resp", {31'd0, x_valid}, 32'd1);
    check("in_ready_resp", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic consume(input int hold);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_bit = 1'b1;
      tick();
      check("bp_res_valid", {31'd0, res_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_x_out", {24'd0, x_out}, {24'd0, exp_q[0][WIDTH-1:0]});
      check("bp_res_data", {31'd0, res_data}, {31'd0, exp_q[0][EW-1]});
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    in_valid = 1'b0;
    check("after_in_ready", {31'd0, in_ready}, 32'd1);
    check("after_res_valid", {31'd0, res_valid}, 32'd0);
    check("after_x_valid", {31'd0, x_valid}, 32'd0);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] op, input bit gap,
                        input logic [EVAL_CYCLES-1:0] zpat, input int hold);
    logic [CNT_W-1:0] pc;
    pc = CNT_W'($countones(op));
    exp_q.push_back({zpat[EVAL_CYCLES-1], pc, op});
    load_bits(op, gap);
    eval_phase(op, zpat);
    consume(hold);
  endtask

  initial begin
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;
    tick();

    run_op(8'hA5, 1'b0, 4'b1111, 0);
    run_op(8'h3E, 1'b0, 4'b0101, 10);
    run_op(8'hFF, 1'b1, 4'b0000, 0);
    run_op(8'h00, 1'b0, 4'b1000, 0);
    run_op(8'h96, 1'b0, 4'b0100, 0);
    for (int r = 0; r < 3; r++) begin
      run_op(WIDTH'($urandom_range(0, 255)), bit'($urandom_range(0, 1)),
             EVAL_CYCLES'($urandom_range(0, 15)), $urandom_range(0, 3));
    end

    // clear after three accepted bits; the bit offered with clear must not land
    in_valid = 1'b1;
    in_bit = 1'b1;
    tick();
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    check("clear_in_ready", {31'd0, in_ready}, 32'd1);
    check("clear_x_valid", {31'd0, x_valid}, 32'd0);
    run_op(8'h3C, 1'b0, 4'b1001, 1);

    // asynchronous reset between edges in the second EVAL cycle
    load_bits(8'hC3, 1'b0);
    tick();
    #2 rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    #2 rst = 1'b0;
    tick();
    run_op(8'h81, 1'b0, 4'b1000, 2);

    check("sb_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
